vga_fb_arbiter: RTL

- Shares one single-port synchronous pixel RAM between two requesters: the VGA scan-out path, which reads one 6-bit {R,G,B} pixel (2 bits per colour) per pixel clock, and a host write port using Avalon-MM style handshakes.
- Keeps a small first-word-fall-through prefetch FIFO ahead of the display so the host can use the RAM between display refill bursts.
- Sits between the 2-bit VGA timing/colour block and the frame-buffer RAM, on the same 40 MHz clock.

---
 rtl/vga_fb_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// vga_fb_arbiter : shares one single-port pixel RAM between VGA scan-out
//                  (FWFT prefetch FIFO) and an Avalon-MM style host write port.
// Optional: VGA_FB_UFLOW_CNT_EN adds a saturating underflow counter.
// Revision: 1.0
//------------------------------------------------------------------------------
module vga_fb_arbiter #(
    parameter int ADDR_W       = 19,
    parameter int FRAME_PIXELS = 480000,
    parameter int FIFO_DEPTH   = 16,
    parameter int LOW_WATER    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vsync_start,
    input  logic              pix_rd,
    output logic [5:0]        pix_data,
    output logic              pix_valid,
    output logic              underflow,
    input  logic              host_write,
    input  logic [ADDR_W-1:0] host_address,
    input  logic [5:0]        host_writedata,
    output logic              host_waitrequest,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [5:0]        mem_writedata,
    input  logic [5:0]        mem_readdata
`ifdef VGA_FB_UFLOW_CNT_EN
    ,
    output logic [15:0]       uflow_cnt
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] c_frame_end = ADDR_W'(FRAME_PIXELS);
    localparam logic [CNT_W-1:0]  c_depth     = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  c_low       = CNT_W'(LOW_WATER);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DISP = 2'd1,
        ST_HOST = 2'd2
    } state_t;

    state_t            r_state;
    logic [5:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_disp_addr;
    logic [CNT_W-1:0]  r_burst;

    logic             w_push;
    logic             w_pop;
    logic             w_uflow_evt;
    logic [CNT_W-1:0] w_count_next;
    logic [CNT_W-1:0] w_fill_next;
    logic             w_frame_left;
    logic             w_room;
    logic             w_idle_disp;
    logic             w_issue;
    logic             w_accept;

    assign pix_valid   = (r_count != '0);
    assign pix_data    = r_mem[r_rd_ptr];
    assign w_push      = r_inflight;
    assign w_pop       = pix_rd & pix_valid;
    assign w_uflow_evt = pix_rd & ~pix_valid;

    // Fill as it will stand after this edge, counting the read issued this cycle
    // as in flight; a new read is only scheduled while this stays below depth.
    assign w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_fill_next  = w_count_next + CNT_W'(mem_read);
    assign w_frame_left = (r_disp_addr < c_frame_end);
    assign w_room       = (w_fill_next < c_depth);

    assign w_idle_disp = w_frame_left &&
                         ((w_fill_next <= c_low) || (w_room && !host_write));
    // Bursts are capped at FIFO_DEPTH reads so a steadily draining FIFO cannot
    // lock the host out indefinitely.
    assign w_issue  = ((r_state == ST_IDLE) && w_idle_disp) ||
                      ((r_state == ST_DISP) && w_frame_left && w_room && (r_burst < c_depth));
    assign w_accept = (r_state == ST_IDLE) && !w_idle_disp && host_write;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push && !vsync_start) begin
            r_mem[r_wr_ptr] <= mem_readdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || vsync_start) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count    <= w_count_next;
            r_inflight <= mem_read;
        end
    end

`ifdef VGA_FB_UFLOW_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || vsync_start) begin
            underflow <= 1'b0;
            uflow_cnt <= '0;
        end else if (w_uflow_evt) begin
            underflow <= 1'b1;
            if (uflow_cnt != 16'hFFFF) begin
                uflow_cnt <= uflow_cnt + 16'd1;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            underflow <= 1'b0;
        end else if (w_uflow_evt) begin
            underflow <= 1'b1;
        end
    end
`endif

    // Outputs are registered: each edge schedules the RAM action of the next cycle.
    always_ff @(posedge clk) begin
        if (reset || vsync_start) begin
            r_state          <= ST_IDLE;
            r_disp_addr      <= '0;
            r_burst          <= '0;
            mem_read         <= 1'b0;
            mem_write        <= 1'b0;
            mem_address      <= '0;
            mem_writedata    <= '0;
            host_waitrequest <= 1'b1;
        end else begin
            mem_read         <= 1'b0;
            mem_write        <= 1'b0;
            host_waitrequest <= 1'b1;
            if (w_issue) begin
                r_state     <= ST_DISP;
                mem_read    <= 1'b1;
                mem_address <= r_disp_addr;
                r_disp_addr <= r_disp_addr + ADDR_W'(1);
                r_burst     <= (r_state == ST_IDLE) ? CNT_W'(1) : r_burst + CNT_W'(1);
            end else if (w_accept) begin
                r_state          <= ST_HOST;
                mem_write        <= 1'b1;
                mem_address      <= host_address;
                mem_writedata    <= host_writedata;
                host_waitrequest <= 1'b0;
            end else begin
                r_state <= ST_IDLE;
            end
        end
    end

endmodule
`default_nettype wire
